mbisr_row_repair_analyzer: RTL and testbench
============================================

# mbisr_row_repair_analyzer

Built-in row-repair analysis stage for one 512x32 memory with two spare rows. It consumes per-cycle fail reports from the memory BIST comparator during a test session and allocates the two spare rows. It also tracks overflow and produces the 22-bit repair word that drives the `D` input of the memory's MBISR repair register. It can seed from the register's current `Q` value, so that repairs accumulate across multiple BIST runs.

## Interface
Parameters:
- `ROW_AW`, 9: failing-row address width. Repair word width is 2*(`ROW_AW`+1)+2 = 22.
- `CNT_W`, 8: width of the saturating fail counter.

Ports:
- `CLK`  in  1  single clock for the whole block; all flops rise-edge.
- `RSTB`  in  1  asynchronous, active-low reset.
- `START`  in  1  single-cycle pulse that opens an analysis session.
- `ACCUM`  in  1  sampled with `START`. 1 = seed from `PRIOR`; 0 = start clean.
- `PRIOR`  in  22  current repair register `Q`.
- `FAIL_VALID`  in  1  BIST comparator reports a failing access this cycle.
- `FAIL_ROW`  in  `ROW_AW`  row address of the failing access.
- `END_TEST`  in  1  BIST session complete.
- `BUSY`  out  1  session in progress (ANALYZE state).
- `DONE`  out  1  analysis complete and `REPAIR_WORD` final.
- `REPAIR_WORD`  out  22  goes to the repair register `D`.
- `FAIL_CNT`  out  `CNT_W`  accepted fail reports, saturating.

Repair word layout:
- [21] `UNREPAIRABLE`
- [20] `NEED_REPAIR`
- [19] `EN1`
- [18:10] `ROW1`
- [9] `EN0`
- [8:0] `ROW0`

## Operation
- The FSM has three states: IDLE, ANALYZE, DONE. Reset state is IDLE.
- IDLE, `START`=1: go to ANALYZE.
  - If `ACCUM`=1, all 22 word bits load from `PRIOR`.
  - Otherwise the word clears to 0.
  - `FAIL_CNT` clears in both cases.
- ANALYZE, `FAIL_VALID`=1: compare `FAIL_ROW` against every entry with EN=1.
  - Hit: entries are unchanged.
  - Miss with a free entry: allocate the lowest-index free entry (entry0 before entry1), set its EN, load its ROW, and set `NEED_REPAIR`.
  - Miss with no free entry: set `UNREPAIRABLE`. The entries are unchanged.
  - `FAIL_CNT` increments on every accepted report, hit or miss, and saturates at 2^`CNT_W`-1.
- `UNREPAIRABLE` and `NEED_REPAIR` are sticky within a session.
- Entries are never freed or overwritten during a session.
- A seeded word with entry0 invalid and entry1 valid is legal. The next new miss allocates entry0.
- ANALYZE, `END_TEST`=1: go to DONE.
  - A `FAIL_VALID` in the same cycle is processed first, so it counts toward both the word and `FAIL_CNT`.
- DONE: `DONE`=1 and the word is frozen.
  - `START` begins a new session with the same seeding rules as IDLE.
  - `FAIL_VALID` and `END_TEST` are ignored.
- Ignored inputs:
  - `START` during ANALYZE.
  - `FAIL_VALID` and `END_TEST` during IDLE.
- `PRIOR` is sampled only in the `START` cycle.

## Timing
- Reset values: state IDLE, `REPAIR_WORD`=0, `FAIL_CNT`=0, `BUSY`=0, `DONE`=0.
- `BUSY` and `DONE` are decoded directly from registered state, with no glitch paths.
- `REPAIR_WORD` and `FAIL_CNT` come straight from flops, with no combinational path from any input.
- `START` sampled at edge n:
  - `BUSY`=1 and the seeded or cleared word are visible after edge n.
  - `DONE` drops after edge n.
- Fail reports:
  - A fail sampled at edge k updates the word and counter after edge k.
  - Back-to-back fails on consecutive cycles are each processed, one per cycle.
  - Comparisons use the entries as they stand after the previous fail has been applied.
  - Two consecutive misses on the same new row therefore allocate only once.
- `END_TEST` sampled at edge m: `BUSY`=0 and `DONE`=1 after edge m, and the word is stable from then on.
- `RSTB` assertion takes effect immediately and asynchronously from any state. All outputs go to their reset values and any partial session is discarded. Deassertion is synchronized externally.
- Downstream hand-off: the repair register captures `REPAIR_WORD` whenever its `SE`=0. The controller must not drop the register `SE` for capture until `DONE`=1.

## Test plan
- Reset, then `START` with `ACCUM`=0; fail rows 0x005, 0x005, 0x1A3; then `END_TEST`.
  - Required: `REPAIR_WORD`=0x1A3<<10 | 1<<19 | 1<<9 | 0x005 | 1<<20, `UNREPAIRABLE`=0, `FAIL_CNT`=3, `DONE`=1.
- Clean session; fails 0x010, 0x020, 0x030 on three consecutive cycles.
  - Required: entries {0x010, 0x020}, `UNREPAIRABLE`=1, `FAIL_CNT`=3.
- `START` with `ACCUM`=1 and `PRIOR`= EN1=1, ROW1=0x0FF, others 0; then fail 0x0FF followed by 0x044.
  - Required: the 0x0FF fail is a hit; 0x044 lands in entry0; `NEED_REPAIR`=1; `UNREPAIRABLE`=0.
- `FAIL_VALID` (row 0x077) in the same cycle as `END_TEST`, on an empty session.
  - Required: EN0=1, ROW0=0x077, `FAIL_CNT`=1, `DONE`=1 one edge later.
- Hold `FAIL_VALID` for 300 cycles on the same row.
  - Required: `FAIL_CNT` saturates at 255; word unchanged after the first cycle.
- Assert `RSTB` mid-ANALYZE after two allocations.
  - Required: immediately `REPAIR_WORD`=0, `BUSY`=0, `FAIL_CNT`=0.
  - `FAIL_VALID` in IDLE afterwards has no effect.

Source files
------------

// File: rtl/mbisr_row_repair_analyzer_if.sv
// Signal bundle between the BIST controller/comparator and the row-repair analyzer.
// The master modport is the controller side; the slave modport is the analyzer.
interface mbisr_row_repair_analyzer_if #(
    parameter int ROW_AW = 9,
    parameter int CNT_W  = 8
);
    localparam int WORD_W = 2 * (ROW_AW + 1) + 2;

    logic              START;
    logic              ACCUM;
    logic [WORD_W-1:0] PRIOR;
    logic              FAIL_VALID;
    logic [ROW_AW-1:0] FAIL_ROW;
    logic              END_TEST;
    logic              BUSY;
    logic              DONE;
    logic [WORD_W-1:0] REPAIR_WORD;
    logic [CNT_W-1:0]  FAIL_CNT;

    modport master (
        output START, ACCUM, PRIOR, FAIL_VALID, FAIL_ROW, END_TEST,
        input  BUSY, DONE, REPAIR_WORD, FAIL_CNT
    );

    modport slave (
        input  START, ACCUM, PRIOR, FAIL_VALID, FAIL_ROW, END_TEST,
        output BUSY, DONE, REPAIR_WORD, FAIL_CNT
    );
endinterface

// File: rtl/mbisr_row_repair_analyzer.sv
// Two-spare-row repair allocator fed by BIST fail reports; builds the repair word
// for the MBISR register and can seed from its current Q so repairs accumulate.
module mbisr_row_repair_analyzer #(
    parameter int ROW_AW = 9,
    parameter int CNT_W  = 8
) (
    input  logic CLK,
    input  logic RSTB,
    mbisr_row_repair_analyzer_if.slave bus
);
    localparam int WORD_W = 2 * (ROW_AW + 1) + 2;
    localparam int EN0_B  = ROW_AW;
    localparam int EN1_B  = 2 * ROW_AW + 1;
    localparam int NEED_B = 2 * ROW_AW + 2;
    localparam int UNRP_B = 2 * ROW_AW + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ANALYZE,
        S_DONE
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              done;

    logic [WORD_W-1:0] word_upd;
    logic [CNT_W-1:0]  cnt_inc;
    logic              hit;

    // Entries are compared as they stand now, so a repeated miss on a row just
    // allocated in the previous cycle is seen as a hit.
    always_comb begin
        word_upd = word;
        hit = (word[EN0_B] && (word[ROW_AW-1:0] == bus.FAIL_ROW)) ||
              (word[EN1_B] && (word[EN1_B-1:ROW_AW+1] == bus.FAIL_ROW));
        if (!hit) begin
            if (!word[EN0_B]) begin
                word_upd[EN0_B]        = 1'b1;
                word_upd[ROW_AW-1:0]   = bus.FAIL_ROW;
                word_upd[NEED_B]       = 1'b1;
            end else if (!word[EN1_B]) begin
                word_upd[EN1_B]            = 1'b1;
                word_upd[EN1_B-1:ROW_AW+1] = bus.FAIL_ROW;
                word_upd[NEED_B]           = 1'b1;
            end else begin
                word_upd[UNRP_B] = 1'b1;
            end
        end
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    end

    // NOTE: all state, including the outputs, is updated with non-blocking
    // assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state <= S_IDLE;
            word  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.START) begin
                        state <= S_ANALYZE;
                        word  <= bus.ACCUM ? bus.PRIOR : '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_ANALYZE: begin
                    if (bus.FAIL_VALID) begin
                        word <= word_upd;
                        cnt  <= cnt_inc;
                    end
                    if (bus.END_TEST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY        = busy;
    assign bus.DONE        = done;
    assign bus.REPAIR_WORD = word;
    assign bus.FAIL_CNT    = cnt;
endmodule

// File: tb/tb_mbisr_row_repair_analyzer.sv
// Self-checking bench: table of one-cycle vectors with hand-computed expectations,
// pushed to a scoreboard when driven and compared after the capturing edge.
module tb_mbisr_row_repair_analyzer;
    localparam int ROW_AW = 9;
    localparam int CNT_W  = 8;

    localparam logic [21:0] UR  = 22'h20_0000;
    localparam logic [21:0] NR  = 22'h10_0000;
    localparam logic [21:0] EN1 = 22'h08_0000;
    localparam logic [21:0] EN0 = 22'h00_0200;

    typedef struct {
        string       name;
        logic        start;
        logic        accum;
        logic [21:0] prior;
        logic        fv;
        logic [8:0]  row;
        logic        end_test;
        logic        busy;
        logic        done;
        logic [21:0] word;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic        busy;
        logic        done;
        logic [21:0] word;
        logic [7:0]  cnt;
    } exp_t;

    logic CLK;
    logic RSTB;
    int   total_cnt;
    int   pass_cnt;
    vec_t vecs[$];
    exp_t sb[$];

    mbisr_row_repair_analyzer_if #(.ROW_AW(ROW_AW), .CNT_W(CNT_W)) bus ();

    mbisr_row_repair_analyzer #(.ROW_AW(ROW_AW), .CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [21:0] r1(input logic [8:0] r);
        return {3'b000, r, 10'b0};
    endfunction

    function automatic logic [21:0] r0(input logic [8:0] r);
        return {13'b0, r};
    endfunction

    function automatic vec_t mk(input string name, input logic start, input logic accum,
                                input logic [21:0] prior, input logic fv, input logic [8:0] row,
                                input logic end_test, input logic busy, input logic done,
                                input logic [21:0] word, input logic [7:0] cnt);
        vec_t v;
        v.name = name; v.start = start; v.accum = accum; v.prior = prior;
        v.fv = fv; v.row = row; v.end_test = end_test;
        v.busy = busy; v.done = done; v.word = word; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({e.name, ".busy"}, 32'(bus.BUSY), 32'(e.busy));
        check({e.name, ".done"}, 32'(bus.DONE), 32'(e.done));
        check({e.name, ".word"}, 32'(bus.REPAIR_WORD), 32'(e.word));
        check({e.name, ".cnt"},  32'(bus.FAIL_CNT), 32'(e.cnt));
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge CLK);
        bus.START      = v.start;
        bus.ACCUM      = v.accum;
        bus.PRIOR      = v.prior;
        bus.FAIL_VALID = v.fv;
        bus.FAIL_ROW   = v.row;
        bus.END_TEST   = v.end_test;
        e.name = v.name; e.busy = v.busy; e.done = v.done; e.word = v.word; e.cnt = v.cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        compare_front();
    endtask

    initial begin
        logic [21:0] w;
        total_cnt = 0;
        pass_cnt  = 0;
        RSTB = 1'b0;
        bus.START = 1'b0; bus.ACCUM = 1'b0; bus.PRIOR = '0;
        bus.FAIL_VALID = 1'b0; bus.FAIL_ROW = '0; bus.END_TEST = 1'b0;

        // Session A: two fails on one row, one on another.
        w = NR | EN0 | r0(9'h005);
        vecs.push_back(mk("a_start", 1, 0, 22'h3F_FFFF, 0, 0, 0, 1, 0, 22'h0, 0));
        vecs.push_back(mk("a_f005",  0, 0, 0, 1, 9'h005, 0, 1, 0, w, 1));
        vecs.push_back(mk("a_f005b", 0, 0, 0, 1, 9'h005, 0, 1, 0, w, 2));
        w = w | EN1 | r1(9'h1A3);
        vecs.push_back(mk("a_f1a3",  0, 0, 0, 1, 9'h1A3, 0, 1, 0, w, 3));
        vecs.push_back(mk("a_end",   0, 0, 0, 0, 0, 1, 0, 1, w, 3));
        vecs.push_back(mk("a_ignore",0, 0, 0, 1, 9'h0EE, 1, 0, 1, w, 3));
        // Session B: overflow on the third distinct row; START while busy is ignored.
        vecs.push_back(mk("b_start", 1, 0, 0, 0, 0, 0, 1, 0, 22'h0, 0));
        w = NR | EN0 | r0(9'h010);
        vecs.push_back(mk("b_f010",  0, 0, 0, 1, 9'h010, 0, 1, 0, w, 1));
        w = w | EN1 | r1(9'h020);
        vecs.push_back(mk("b_f020",  0, 0, 0, 1, 9'h020, 0, 1, 0, w, 2));
        w = w | UR;
        vecs.push_back(mk("b_f030",  0, 0, 0, 1, 9'h030, 0, 1, 0, w, 3));
        vecs.push_back(mk("b_restart", 1, 1, 22'h15_5555, 0, 0, 0, 1, 0, w, 3));
        vecs.push_back(mk("b_end",   0, 0, 0, 0, 0, 1, 0, 1, w, 3));
        // Session C: seeded with only entry1 valid; hit on it, then allocate entry0.
        w = EN1 | r1(9'h0FF);
        vecs.push_back(mk("c_start", 1, 1, w, 0, 0, 0, 1, 0, w, 0));
        vecs.push_back(mk("c_f0ff",  0, 0, 0, 1, 9'h0FF, 0, 1, 0, w, 1));
        w = w | NR | EN0 | r0(9'h044);
        vecs.push_back(mk("c_f044",  0, 0, 0, 1, 9'h044, 0, 1, 0, w, 2));
        vecs.push_back(mk("c_end",   0, 0, 0, 0, 0, 1, 0, 1, w, 2));
        // Session D: fail in the END_TEST cycle still counts.
        vecs.push_back(mk("d_start", 1, 0, 0, 0, 0, 0, 1, 0, 22'h0, 0));
        w = NR | EN0 | r0(9'h077);
        vecs.push_back(mk("d_fail_end", 0, 0, 0, 1, 9'h077, 1, 0, 1, w, 1));

        repeat (2) @(posedge CLK);
        #1;
        check("reset.busy", 32'(bus.BUSY), 32'd0);
        check("reset.done", 32'(bus.DONE), 32'd0);
        check("reset.word", 32'(bus.REPAIR_WORD), 32'd0);
        check("reset.cnt",  32'(bus.FAIL_CNT), 32'd0);
        @(negedge CLK);
        RSTB = 1'b1;

        // Fails while IDLE must be ignored.
        apply(mk("idle_fail", 0, 0, 0, 1, 9'h123, 1, 0, 0, 22'h0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Saturation: same row held for 300 cycles.
        apply(mk("s_start", 1, 0, 0, 0, 0, 0, 1, 0, 22'h0, 0));
        w = NR | EN0 | r0(9'h0AB);
        for (int i = 0; i < 300; i++)
            apply(mk($sformatf("sat%0d", i), 0, 0, 0, 1, 9'h0AB, 0, 1, 0, w,
                     (i + 1 > 255) ? 8'd255 : 8'(i + 1)));
        apply(mk("s_end", 0, 0, 0, 0, 0, 1, 0, 1, w, 255));

        // Asynchronous reset mid-session after two allocations.
        apply(mk("r_start", 1, 0, 0, 0, 0, 0, 1, 0, 22'h0, 0));
        apply(mk("r_f011",  0, 0, 0, 1, 9'h011, 0, 1, 0, NR | EN0 | r0(9'h011), 1));
        w = NR | EN0 | r0(9'h011) | EN1 | r1(9'h022);
        apply(mk("r_f022",  0, 0, 0, 1, 9'h022, 0, 1, 0, w, 2));
        #1;
        RSTB = 1'b0;
        #1;
        check("rst_async.busy", 32'(bus.BUSY), 32'd0);
        check("rst_async.done", 32'(bus.DONE), 32'd0);
        check("rst_async.word", 32'(bus.REPAIR_WORD), 32'd0);
        check("rst_async.cnt",  32'(bus.FAIL_CNT), 32'd0);
        #1;
        RSTB = 1'b1;
        apply(mk("post_rst_fail", 0, 0, 0, 1, 9'h033, 0, 0, 0, 22'h0, 0));
        apply(mk("post_rst_end",  0, 0, 0, 0, 0, 1, 0, 0, 22'h0, 0));
        apply(mk("post_rst_start", 1, 0, 0, 0, 0, 0, 1, 0, 22'h0, 0));
        apply(mk("post_rst_f033", 0, 0, 0, 1, 9'h033, 0, 1, 0, NR | EN0 | r0(9'h033), 1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
